// File: rtl/stream_trigger.sv
// Trigger/gating stage in front of the stream capture buffer: arms under APB control,
// detects a masked data match and forwards pre-trigger, trigger and post-trigger beats.
module stream_trigger #(
  parameter int DataBits = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataBits-1:0] din_data,
  input  logic                din_valid,
  input  logic                din_ready,
  output logic [DataBits-1:0] dout_data,
  output logic                dout_valid,
  output logic                dout_ready,
  output logic                done,
  input  logic [4:0]          cfg_paddr,
  input  logic                cfg_psel,
  input  logic                cfg_penable,
  input  logic                cfg_pwrite,
  input  logic [31:0]         cfg_pwdata,
  output logic                cfg_pready,
  output logic [31:0]         cfg_prdata,
  output logic                cfg_pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_match(input logic [DataBits-1:0] d,
                                    input logic [DataBits-1:0] m,
                                    input logic [DataBits-1:0] k);
    return ((d ^ m) & k) == {DataBits{1'b0}};
  endfunction

  state_t              state_r;
  logic                pretrig_en_r;
  logic [DataBits-1:0] match_r;
  logic [DataBits-1:0] mask_r;
  logic [15:0]         post_count_r;
  logic [15:0]         remaining_r;
  logic [15:0]         fwd_count_r;
  logic [15:0]         trig_index_r;
  logic                pready_r;
  logic [31:0]         prdata_r;

  logic                beat_s;
  logic                hit_s;
  logic                fwd_s;
  logic                setup_s;
  logic                wr_s;
  logic                rd_s;
  logic [2:0]          waddr_s;
  logic                cmd_wr_s;
  logic [31:0]         rd_data_s;
  logic                unused_s;

  assign beat_s   = din_valid & din_ready;
  assign hit_s    = beat_s & is_match(din_data, match_r, mask_r);
  assign fwd_s    = ((state_r == ST_ARMED) & (pretrig_en_r | hit_s)) | (state_r == ST_TRIG);
  assign setup_s  = cfg_psel & ~cfg_penable;
  assign wr_s     = setup_s & cfg_pwrite;
  assign rd_s     = setup_s & ~cfg_pwrite;
  assign waddr_s  = cfg_paddr[4:2];
  assign cmd_wr_s = wr_s & (waddr_s == 3'd1);

  assign dout_data   = din_data;
  assign dout_ready  = din_ready;
  assign dout_valid  = din_valid & fwd_s;
  assign done        = (state_r == ST_DONE);
  assign cfg_pready  = pready_r;
  assign cfg_prdata  = prdata_r;
  assign cfg_pslverr = 1'b0;
  assign unused_s    = ^{cfg_paddr, cfg_pwdata};

  // Register read multiplexer
  always_comb begin
    rd_data_s = 32'd0;
    case (waddr_s)
      3'd0:    rd_data_s[0] = pretrig_en_r;
      3'd2:    rd_data_s[DataBits-1:0] = match_r;
      3'd3:    rd_data_s[DataBits-1:0] = mask_r;
      3'd4:    rd_data_s[15:0] = post_count_r;
      3'd5:    rd_data_s[1:0] = state_r;
      3'd6:    rd_data_s[15:0] = trig_index_r;
      3'd7:    rd_data_s[15:0] = fwd_count_r;
      default: rd_data_s = 32'd0;
    endcase
  end

  // Trigger FSM, counters and APB register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pretrig_en_r <= 1'b0;
      match_r      <= {DataBits{1'b0}};
      mask_r       <= {DataBits{1'b0}};
      post_count_r <= 16'd0;
      remaining_r  <= 16'd0;
      fwd_count_r  <= 16'd0;
      trig_index_r <= 16'd0;
      pready_r     <= 1'b0;
      prdata_r     <= 32'd0;
    end else begin
      pready_r <= setup_s;
      if (rd_s) begin
        prdata_r <= rd_data_s;
      end

      if (wr_s) begin
        case (waddr_s)
          3'd0:    pretrig_en_r <= cfg_pwdata[0];
          3'd2:    match_r      <= cfg_pwdata[DataBits-1:0];
          3'd3:    mask_r       <= cfg_pwdata[DataBits-1:0];
          3'd4:    post_count_r <= cfg_pwdata[15:0];
          default: ;
        endcase
      end

      if (beat_s & fwd_s) begin
        fwd_count_r <= fwd_count_r + 16'd1;
      end

      // A command overrides whatever the stream would have done this cycle
      if (cmd_wr_s & cfg_pwdata[1]) begin
        state_r <= ST_IDLE;
      end else if (cmd_wr_s & cfg_pwdata[0]) begin
        state_r      <= ST_ARMED;
        fwd_count_r  <= 16'd0;
        trig_index_r <= 16'd0;
      end else begin
        case (state_r)
          ST_ARMED: begin
            if (hit_s) begin
              trig_index_r <= fwd_count_r;
              if (post_count_r == 16'd0) begin
                state_r <= ST_DONE;
              end else begin
                remaining_r <= post_count_r;
                state_r     <= ST_TRIG;
              end
            end
          end
          ST_TRIG: begin
            if (beat_s) begin
              remaining_r <= remaining_r - 16'd1;
              if (remaining_r == 16'd1) begin
                state_r <= ST_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_trigger.sv
// Self-checking bench for stream_trigger: directed scenarios plus randomized capture
// runs compared against a beat-list model of the expected forwarded window.
module tb_stream_trigger;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_data = '0;
  logic          din_valid = 1'b0;
  logic          din_ready = 1'b0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready;
  logic          done;
  logic [4:0]    cfg_paddr = 5'd0;
  logic          cfg_psel = 1'b0;
  logic          cfg_penable = 1'b0;
  logic          cfg_pwrite = 1'b0;
  logic [31:0]   cfg_pwdata = 32'd0;
  logic          cfg_pready;
  logic [31:0]   cfg_prdata;
  logic          cfg_pslverr;

  always #5 clk = ~clk;

  stream_trigger #(.DataBits(DW)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .done(done),
    .cfg_paddr(cfg_paddr), .cfg_psel(cfg_psel), .cfg_penable(cfg_penable),
    .cfg_pwrite(cfg_pwrite), .cfg_pwdata(cfg_pwdata),
    .cfg_pready(cfg_pready), .cfg_prdata(cfg_prdata), .cfg_pslverr(cfg_pslverr)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic          mon_en = 1'b0;
  logic [DW-1:0] seen_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("passthru", {dout_data, dout_ready, cfg_pslverr}, {din_data, din_ready, 1'b0});
      if (dout_valid && dout_ready) seen_q.push_back(dout_data);
    end
  end

  task automatic drive(input logic v, input logic r, input logic [DW-1:0] d);
    din_valid = v; din_ready = r; din_data = d;
    @(posedge clk); #1;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
    cfg_paddr = {a, 2'b00}; cfg_pwdata = d; cfg_pwrite = 1'b1;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(negedge clk);
    check_eq("wr_pready", cfg_pready, 1);
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    cfg_paddr = {a, 2'b00}; cfg_pwrite = 1'b0;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(negedge clk);
    check_eq("rd_pready", cfg_pready, 1);
    d = cfg_prdata;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0;
    check_eq("rd_pready_drop", cfg_pready, 0);
    check_eq(tag, d, exp);
  endtask

  logic          sv[64];
  logic          sr[64];
  logic [DW-1:0] sd[64];

  // Model: list the beats, find the first hit, the forwarded window follows from it.
  task automatic run_case(input string tag, input logic pre, input logic [DW-1:0] match,
                          input logic [DW-1:0] mask, input int post, input int n);
    logic [DW-1:0] beats[$];
    logic [DW-1:0] exp_q[$];
    int k, last, exp_state, exp_trig;
    k = -1;
    for (int i = 0; i < n; i++) if (sv[i] && sr[i]) beats.push_back(sd[i]);
    for (int i = 0; i < beats.size(); i++)
      if (k < 0 && ((beats[i] ^ match) & mask) == 0) k = i;
    if (k < 0) begin
      if (pre) exp_q = beats;
      exp_state = 1; exp_trig = 0;
    end else begin
      if (pre) for (int i = 0; i < k; i++) exp_q.push_back(beats[i]);
      last = k + post;
      if (last > beats.size() - 1) last = beats.size() - 1;
      for (int i = k; i <= last; i++) exp_q.push_back(beats[i]);
      exp_trig = pre ? k : 0;
      exp_state = (post == 0 || beats.size() - 1 - k >= post) ? 3 : 2;
    end

    din_valid = 1'b0; din_ready = 1'b0;
    apb_write(3'd3, {24'd0, mask});
    apb_write(3'd2, {24'd0, match});
    apb_write(3'd4, post);
    apb_write(3'd0, {31'd0, pre});
    apb_write(3'd1, 32'd1);
    seen_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) drive(sv[i], sr[i], sd[i]);
    din_valid = 1'b0; din_ready = 1'b0;
    mon_en = 1'b0;

    check_eq({tag, "_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_data"}, seen_q[i], exp_q[i]);
    check_eq({tag, "_done"}, done, (exp_state == 3) ? 1 : 0);
    read_check(3'd5, exp_state, {tag, "_status"});
    read_check(3'd6, exp_trig, {tag, "_trigidx"});
    read_check(3'd7, exp_q.size(), {tag, "_fwdcnt"});
  endtask

  task automatic load_pattern(input int rdy_stall);
    logic [DW-1:0] pat[7];
    int j;
    pat = '{8'h10, 8'h20, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
    j = 0;
    for (int i = 0; i < 7; i++) begin
      if (rdy_stall != 0 && i >= 2) begin
        sv[j] = 1'b1; sr[j] = 1'b0; sd[j] = pat[i]; j++;
      end
      sv[j] = 1'b1; sr[j] = 1'b1; sd[j] = pat[i]; j++;
    end
  endtask

  initial begin
    din_valid = 1'b1; din_ready = 1'b1; din_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pready", cfg_pready, 0);
    check_eq("rst_prdata", cfg_prdata, 0);
    @(posedge clk); #1;
    din_valid = 1'b0; din_ready = 1'b0;
    read_check(3'd5, 0, "rst_status");
    read_check(3'd0, 0, "rst_ctrl");
    read_check(3'd2, 0, "rst_match");
    read_check(3'd3, 0, "rst_mask");
    read_check(3'd4, 0, "rst_post");
    read_check(3'd6, 0, "rst_trigidx");
    read_check(3'd7, 0, "rst_fwdcnt");

    apb_write(3'd0, 32'hFFFF_FFFF);
    read_check(3'd0, 1, "ctrl_rb");
    apb_write(3'd2, 32'hFFFF_FF5A);
    read_check(3'd2, 32'h5A, "match_rb");
    apb_write(3'd3, 32'h1234_56C3);
    read_check(3'd3, 32'hC3, "mask_rb");
    apb_write(3'd4, 32'hABCD_1234);
    read_check(3'd4, 32'h1234, "post_rb");
    read_check(3'd1, 0, "cmd_rd");

    load_pattern(0);
    run_case("masked", 1'b0, 8'hA0, 8'hF0, 3, 7);
    load_pattern(0);
    run_case("pretrig", 1'b1, 8'hA0, 8'hF0, 0, 7);
    load_pattern(1);
    run_case("bkpress", 1'b0, 8'hA0, 8'hF0, 3, 12);

    // Abort while triggered, with a post_count change that must not disturb remaining
    apb_write(3'd3, 32'd0);
    apb_write(3'd4, 32'd10);
    apb_write(3'd0, 32'd0);
    apb_write(3'd1, 32'd1);
    drive(1'b1, 1'b1, 8'h33);
    din_valid = 1'b0;
    apb_write(3'd4, 32'd1);
    read_check(3'd5, 2, "trig_status");
    drive(1'b1, 1'b1, 8'h34);
    din_valid = 1'b0;
    read_check(3'd5, 2, "post_chg_status");
    din_valid = 1'b1; din_ready = 1'b1; din_data = 8'h35;
    cfg_paddr = {3'd1, 2'b00}; cfg_pwdata = 32'd2; cfg_pwrite = 1'b1;
    cfg_psel = 1'b1; cfg_penable = 1'b0;
    @(negedge clk);
    check_eq("abort_setup_fwd", dout_valid, 1);
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    @(negedge clk);
    check_eq("abort_stop_fwd", dout_valid, 0);
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0; din_valid = 1'b0;
    read_check(3'd5, 0, "abort_status");
    read_check(3'd7, 3, "abort_fwdcnt");

    apb_write(3'd1, 32'd3);
    read_check(3'd5, 0, "arm_abort_status");

    apb_write(3'd4, 32'd0);
    apb_write(3'd1, 32'd1);
    drive(1'b1, 1'b1, 8'h00);
    din_valid = 1'b0;
    check_eq("done_high", done, 1);
    read_check(3'd5, 3, "done_status");
    apb_write(3'd1, 32'd1);
    check_eq("rearm_done", done, 0);
    read_check(3'd5, 1, "rearm_status");
    read_check(3'd7, 0, "rearm_fwdcnt");

    // Reset mid-capture stops forwarding immediately
    apb_write(3'd4, 32'd10);
    apb_write(3'd1, 32'd1);
    drive(1'b1, 1'b1, 8'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_fwd", dout_valid, 0);
    @(posedge clk); #1;
    din_valid = 1'b0; din_ready = 1'b0;
    read_check(3'd5, 0, "rst_mid_status");

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(5, 30);
      for (int i = 0; i < n; i++) begin
        sv[i] = ($urandom % 4) != 0;
        sr[i] = ($urandom % 4) != 0;
        sd[i] = $urandom;
      end
      run_case("rand", $urandom % 2, $urandom, ($urandom & $urandom & $urandom), $urandom_range(0, 5), n);
    end

    apb_write(3'd0, 32'd1);
    apb_write(3'd2, 32'd0);
    apb_write(3'd3, 32'hFF);
    apb_write(3'd1, 32'd1);
    din_valid = 1'b1; din_ready = 1'b1; din_data = 8'h55;
    repeat (65536) @(posedge clk);
    #1;
    din_valid = 1'b0; din_ready = 1'b0;
    read_check(3'd7, 0, "wrap_fwdcnt");
    read_check(3'd5, 1, "wrap_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
